// File: rtl/ifid_skid_stage.sv
// ifid_skid_stage: two-entry IF/ID skid buffer with flush, sticky halt and registered in_ready.
module ifid_skid_stage #(
    parameter int IW = 16,
    parameter int PW = 16,
    parameter logic [IW-1:0] NOP_INSTR = 16'h0800,
    parameter logic [IW-1:0] HALT_INSTR = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [PW-1:0] in_pc_next,
    input  logic          in_pred_taken,
    input  logic          in_err,
    input  logic          flush,
    input  logic          halt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [PW-1:0] out_pc_next,
    output logic          out_pred_taken,
    output logic          out_err,
    output logic [1:0]    occupancy
);
    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PW-1:0] pc;
        logic          pt;
        logic          err;
        logic          v;
    } ent_t;

    ent_t main_q, main_d, skid_q, skid_d, new_e;
    logic halted_q, halted_d, rdy_q, rdy_d;
    logic acc, cons;
    logic [1:0] occ_d;

    assign acc = in_valid & rdy_q;
    assign cons = main_q.v & out_ready;
    assign new_e = '{instr: halt ? HALT_INSTR : in_instr, pc: in_pc_next,
                     pt: in_pred_taken, err: in_err, v: 1'b1};

    // Invalid entries are always zeroed, so shifting skid into main never leaks payload.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        halted_d = halted_q;
        if (flush) begin
            main_d = '0;
            skid_d = '0;
        end else begin
            if (cons) begin
                main_d = skid_q;
                skid_d = '0;
            end
            if (acc) begin
                if (!main_d.v) main_d = new_e;
                else skid_d = new_e;
                if (halt) halted_d = 1'b1;
            end
        end
        occ_d = 2'(main_d.v) + 2'(skid_d.v);
        rdy_d = (occ_d != 2'd2) && !halted_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
            halted_q <= 1'b0;
            rdy_q <= 1'b1;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
            halted_q <= halted_d;
            rdy_q <= rdy_d;
        end
    end

    assign in_ready = rdy_q;
    assign out_valid = main_q.v;
    assign out_instr = main_q.v ? main_q.instr : NOP_INSTR;
    assign out_pc_next = main_q.v ? main_q.pc : '0;
    assign out_pred_taken = main_q.v & main_q.pt;
    assign out_err = main_q.v & main_q.err;
    assign occupancy = 2'(main_q.v) + 2'(skid_q.v);
endmodule

// File: tb/tb_ifid_skid_stage.sv
// tb_ifid_skid_stage: directed and randomized checks against a queue-based model of the stage.
module tb_ifid_skid_stage;
    localparam int IW = 16;
    localparam int PW = 16;
    localparam logic [IW-1:0] NOP = 16'h0800;
    localparam logic [IW-1:0] HLT = 16'h0000;

    logic clk = 0, rst = 0;
    logic in_valid = 0, in_pred_taken = 0, in_err = 0, flush = 0, halt = 0, out_ready = 0;
    logic [IW-1:0] in_instr = 0;
    logic [PW-1:0] in_pc_next = 0;
    logic in_ready, out_valid, out_pred_taken, out_err;
    logic [IW-1:0] out_instr;
    logic [PW-1:0] out_pc_next;
    logic [1:0] occupancy;

    ifid_skid_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_next(in_pc_next), .in_pred_taken(in_pred_taken),
        .in_err(in_err), .flush(flush), .halt(halt), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc_next(out_pc_next),
        .out_pred_taken(out_pred_taken), .out_err(out_err), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    logic [IW+PW+1:0] q[$];
    bit hm = 0;
    bit chk_en = 0;
    int vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        hm = 0;
    endtask

    task automatic model_step();
        bit acc, cons;
        if (!rst) return;
        acc = in_valid && q.size() < 2 && !hm;
        cons = q.size() > 0 && out_ready;
        if (flush) q.delete();
        else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
                q.push_back({halt ? HLT : in_instr, in_pc_next, in_pred_taken, in_err});
                if (halt) hm = 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [IW-1:0] ins, input bit ordy);
        in_valid = v;
        in_instr = ins;
        out_ready = ordy;
    endtask

    always @(negedge clk) begin
        logic [IW+PW+1:0] h;
        bit mv;
        if (chk_en) begin
            mv = q.size() > 0;
            h = mv ? q[0] : '0;
            chk("out_valid", out_valid, mv);
            chk("out_instr", out_instr, mv ? h[IW+PW+1:PW+2] : NOP);
            chk("out_pc_next", out_pc_next, h[PW+1:2]);
            chk("out_pred_taken", out_pred_taken, h[1]);
            chk("out_err", out_err, h[0]);
            chk("occupancy", occupancy, q.size());
            chk("in_ready", in_ready, q.size() < 2 && !hm);
        end
    end

    initial begin
        model_reset();
        #12 rst = 1;
        chk_en = 1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_instr", out_instr, 16'h0800);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        drive(1, 16'h1234, 1);
        cyc();
        chk("lat_valid", out_valid, 1);
        chk("lat_instr", out_instr, 16'h1234);
        drive(0, 0, 1);
        cyc();
        chk("lat_drain_valid", out_valid, 0);
        chk("lat_drain_instr", out_instr, 16'h0800);
        drive(1, 16'hA001, 0);
        cyc();
        drive(1, 16'hA002, 0);
        cyc();
        drive(0, 0, 0);
        chk("full_occ", occupancy, 2);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", out_instr, 16'hA001);
        out_ready = 1;
        cyc();
        chk("skid_head", out_instr, 16'hA002);
        chk("skid_in_ready", in_ready, 1);
        cyc();
        chk("skid_empty", occupancy, 0);
        drive(1, 16'hA001, 0);
        cyc();
        drive(1, 16'hA002, 0);
        cyc();
        drive(1, 16'hBEEF, 0);
        flush = 1;
        cyc();
        flush = 0;
        drive(0, 0, 0);
        chk("flush_occ", occupancy, 0);
        chk("flush_instr", out_instr, 16'h0800);
        cyc();
        chk("flush_nobeef", out_instr, 16'h0800);
        drive(1, 16'hA003, 0);
        cyc();
        drive(1, 16'hBEEF, 1);
        flush = 1;
        cyc();
        flush = 0;
        drive(0, 0, 0);
        chk("flush1_occ", occupancy, 0);
        chk("flush1_valid", out_valid, 0);
        drive(1, 16'h5555, 0);
        in_pc_next = 16'h0042;
        halt = 1;
        cyc();
        halt = 0;
        in_pc_next = 0;
        drive(0, 0, 0);
        chk("halt_instr", out_instr, 16'h0000);
        chk("halt_pc", out_pc_next, 16'h0042);
        chk("halt_in_ready", in_ready, 0);
        flush = 1;
        cyc();
        flush = 0;
        chk("halt_flush_ready", in_ready, 0);
        drive(1, 16'h6666, 1);
        cyc();
        chk("halt_sticky_ready", in_ready, 0);
        chk("halt_sticky_occ", occupancy, 0);
        drive(0, 0, 0);
        #2 rst = 0;
        model_reset();
        #1 chk("halt_rst_ready", in_ready, 1);
        #1 rst = 1;
        @(negedge clk);
        drive(1, 16'hC001, 0);
        cyc();
        drive(1, 16'hC002, 0);
        cyc();
        drive(0, 0, 0);
        chk("pre_async_occ", occupancy, 2);
        #2 rst = 0;
        model_reset();
        #1;
        chk("async_occ", occupancy, 0);
        chk("async_valid", out_valid, 0);
        chk("async_instr", out_instr, 16'h0800);
        chk("async_ready", in_ready, 1);
        drive(1, 16'h7777, 0);
        #1 rst = 1;
        cyc();
        chk("post_rst_accept", out_instr, 16'h7777);
        drive(0, 0, 1);
        cyc();
        for (int i = 0; i < 4000; i++) begin
            in_valid = ($urandom % 4) != 0;
            out_ready = $urandom % 2;
            flush = ($urandom % 16) == 0;
            halt = !flush && ($urandom % 150) == 0;
            in_instr = IW'($urandom);
            in_pc_next = PW'($urandom);
            in_pred_taken = $urandom % 2;
            in_err = $urandom % 2;
            if (($urandom % 120) == 0) begin
                #2 rst = 0;
                model_reset();
                #2 rst = 1;
            end
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
